muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have a single clock; reset is asynchronous and active-low.
REQ-002 The block SHALL expose parameter XLEN, default 32, giving the operand/result width (legal values 8..64, even).
REQ-003 The block SHALL expose these ports, clock and reset first:
 clk     input   1     rising-edge clock
 rst     input   1     asynchronous, active-low reset
 start   input   1     request; accepted only when ready=1
 op      input   3     RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
 A       input   XLEN  operand rs1 / dividend
 B       input   XLEN  operand rs2 / divisor
 flush   input   1     abort the current operation
 ready   output  1     idle, can accept start
 busy    output  1     operation in progress
 done    output  1     one-cycle pulse, Result valid
 Result  output  XLEN  result, held until the next accepted start
 zero    output  1     Result == 0, qualified by done
 divzero output  1     divisor was 0 on a DIV/DIVU/REM/REMU, qualified by done

Function
REQ-004 The FSM SHALL have the states IDLE, CALC, FIX and DONE.
REQ-005 In IDLE, ready SHALL be 1 and busy 0; start=1 SHALL capture op, A and B on that edge and move the FSM to CALC.
REQ-006 In CALC, the block SHALL perform one iteration per cycle for exactly XLEN cycles, using shift-add for multiply and restoring shift-subtract for divide, then move to FIX.
REQ-007 In FIX, the block SHALL apply sign correction: negate the product, quotient or remainder per operand signs; remainder sign follows the dividend.
REQ-008 In DONE, done and Result SHALL be valid for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-009 Latency SHALL be fixed: done is high in the cycle XLEN+2 edges after the accepting edge (34 for XLEN=32) for every op, including corner cases.
REQ-010 Signed operands SHALL be converted to magnitudes at capture. MULHSU SHALL treat A as signed and B as unsigned.
REQ-011 MUL SHALL return the low XLEN bits of the 2*XLEN product; MULH, MULHSU and MULHU SHALL return the high XLEN bits.
REQ-012 Divide by zero: quotient SHALL be all ones, remainder SHALL be A, and divzero SHALL be 1.
REQ-013 Signed overflow (A = most-negative, B = -1) on DIV SHALL return the most-negative value; on REM it SHALL return 0. divzero SHALL be 0.
REQ-014 start while busy SHALL be ignored; ready SHALL be 0 in CALC, FIX and DONE.
REQ-015 flush=1 in CALC or FIX SHALL return the FSM to IDLE on the next edge with no done pulse. Result SHALL keep its previous value.
REQ-016 If flush and start are both high in IDLE, flush SHALL win and the request SHALL NOT be accepted.
REQ-017 start is accepted again in the cycle after DONE (back-to-back issue), with no idle gap beyond that cycle.

Reset
REQ-018 rst=0 SHALL force, asynchronously, state IDLE, Result=0, done=0, busy=0, ready=1, zero=0, divzero=0 and the iteration counter to 0.
REQ-019 Reset asserted mid-operation SHALL discard that operation; no done SHALL follow reset release.

Structure
REQ-020 Package muldiv_pkg SHALL hold the op encoding enum (muldiv_op_t), the state enum (muldiv_state_t) and the op-class helper constants.
REQ-021 The block SHALL be a single module with no sub-module. The counter width SHALL be $clog2(XLEN+1).

Verification (XLEN=32)
REQ-022 MUL: A=7, B=0xFFFFFFFD -> Result=0xFFFFFFEB, with done exactly 34 cycles after start.
REQ-023 MULH: A=B=0x80000000 -> Result=0x40000000. MULHU with the same operands -> 0x40000000. MULHSU: A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
REQ-024 DIVU: 100/7 -> 14, then back-to-back REMU: 100/7 -> 2. The second start is issued the cycle after done.
REQ-025 DIV: 5/0 -> 0xFFFFFFFF with divzero=1. REM: 5/0 -> 5. DIV: 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same -> 0 with zero=1.
REQ-026 DIV: -7/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF. Then flush asserted 10 cycles in -> no done, ready=1 next cycle, Result unchanged.
REQ-027 rst pulsed low 5 cycles into a MUL -> all outputs at reset values immediately and no done within 40 cycles after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and op-class masks for the iterative multiply/divide unit.
// Each mask is indexed by the RV32M funct3 encoding.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } muldiv_state_t;

  // Bit i of each mask is set when op encoding i belongs to the class.
  localparam logic [7:0] OPS_DIV      = 8'b1111_0000;
  localparam logic [7:0] OPS_REM      = 8'b1100_0000;
  localparam logic [7:0] OPS_HIGH     = 8'b0000_1110;
  localparam logic [7:0] OPS_A_SIGNED = 8'b0101_0110;
  localparam logic [7:0] OPS_B_SIGNED = 8'b0101_0010;

  function automatic logic op_in(input logic [7:0] mask, input muldiv_op_t op);
    return mask[op];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: XLEN-cycle shift-add / restoring divide on
// operand magnitudes, then a sign-correction cycle and a one-cycle done pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result,
  output logic            zero,
  output logic            divzero
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  muldiv_state_t state, state_nxt;
  muldiv_op_t    op_q;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] hi, lo;
  logic [CW-1:0]   cnt;
  logic            res_neg_q, rem_neg_q, dz_q;

  // Operand conditioning at capture time.
  muldiv_op_t      op_in_cur;
  logic            a_neg, b_neg, accept, is_div_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in;

  assign op_in_cur = muldiv_op_t'(op);
  assign is_div_in = op_in(OPS_DIV, op_in_cur);
  assign a_neg     = op_in(OPS_A_SIGNED, op_in_cur) & A[XLEN-1];
  assign b_neg     = op_in(OPS_B_SIGNED, op_in_cur) & B[XLEN-1];
  assign a_mag_in  = a_neg ? -A : A;
  assign b_mag_in  = b_neg ? -B : B;
  assign accept    = (state == ST_IDLE) && start && !flush;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = ST_CALC;
      ST_CALC: begin
        if (flush)                  state_nxt = ST_IDLE;
        else if (cnt == LAST_ITER)  state_nxt = ST_FIX;
      end
      ST_FIX:  state_nxt = flush ? ST_IDLE : ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // One iteration step for each algorithm.
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_ge;

  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, a_mag} : '0);
  assign div_shift = {hi, lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_mag};
  assign div_ge    = (div_shift >= {1'b0, b_mag});

  // Sign correction and result selection, registered in FIX.
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  assign prod     = {hi, lo};
  assign prod_fix = res_neg_q ? -prod : prod;
  assign quo_fix  = dz_q ? '1 : (res_neg_q ? -lo : lo);
  assign rem_fix  = rem_neg_q ? -hi : hi;

  always_comb begin
    fix_result = prod_fix[XLEN-1:0];
    if (op_in(OPS_DIV, op_q))       fix_result = op_in(OPS_REM, op_q) ? rem_fix : quo_fix;
    else if (op_in(OPS_HIGH, op_q)) fix_result = prod_fix[2*XLEN-1:XLEN];
  end

  // NOTE: the datapath registers are few, so all of them are reset; this keeps
  // Result at zero after reset and avoids X propagation into the comparators.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= OP_MUL;
      a_mag     <= '0;
      b_mag     <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      Result    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (accept) begin
          op_q      <= op_in_cur;
          a_mag     <= a_mag_in;
          b_mag     <= b_mag_in;
          hi        <= '0;
          lo        <= is_div_in ? a_mag_in : b_mag_in;
          cnt       <= '0;
          res_neg_q <= a_neg ^ b_neg;
          rem_neg_q <= a_neg;
          dz_q      <= is_div_in && (B == '0);
        end
        ST_CALC: begin
          cnt <= cnt + 1'b1;
          if (op_in(OPS_DIV, op_q)) begin
            // Restoring step: keep the shifted partial remainder when it is
            // smaller than the divisor.
            hi <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo <= {lo[XLEN-2:0], div_ge};
          end else begin
            hi <= mul_sum[XLEN:1];
            lo <= {mul_sum[0], lo[XLEN-1:1]};
          end
        end
        ST_FIX: if (!flush) Result <= fix_result;
        default: ;
      endcase
    end
  end

  assign ready   = (state == ST_IDLE);
  assign busy    = !ready;
  assign done    = (state == ST_DONE);
  assign zero    = done && (Result == '0);
  assign divzero = done && dz_q;

endmodule
